// File: rtl/pim_pipe_core_if.sv
// Command/response bundle for pim_pipe_core: valid/ready command channel,
// valid/ready read-response channel and the sticky overflow flag.
interface pim_pipe_core_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] addr_result;
  logic [DATA_W-1:0] write_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              ovf_flag;
  logic              flag_clr;

  modport master (
    output cmd_valid, opcode, addr_a, addr_b, addr_result, write_data,
    output rsp_ready, flag_clr,
    input  cmd_ready, rsp_valid, rsp_data, ovf_flag
  );

  modport slave (
    input  cmd_valid, opcode, addr_a, addr_b, addr_result, write_data,
    input  rsp_ready, flag_clr,
    output cmd_ready, rsp_valid, rsp_data, ovf_flag
  );
endinterface

// File: rtl/pim_pipe_core.sv
// Two-stage in-memory compute array with read-after-write forwarding,
// response backpressure and a sticky overflow flag. Define PIM_SAT_EN for saturating add/sub.
module pim_pipe_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input logic             clk,
  input logic             rst_n,
  pim_pipe_core_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int MSB   = DATA_W - 1;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_WRITE = 3'b100,
    OP_NOP   = 3'b101,
    OP_RSVD  = 3'b110,
    OP_READ  = 3'b111
  } op_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              s1_valid;
  op_t               s1_op;
  logic [ADDR_W-1:0] s1_addr_result;
  logic [DATA_W-1:0] s1_wdata;
  logic [DATA_W-1:0] s1_opa;
  logic [DATA_W-1:0] s1_opb;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovf;

  logic              s1_writes;
  logic              s1_stall;
  logic              s1_advance;
  logic              accept;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              ovf_flag;

  assign s1_writes  = s1_valid && (s1_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_WRITE});
  assign s1_stall   = s1_valid && (s1_op == OP_READ) && rsp_valid && !bus.rsp_ready;
  assign s1_advance = s1_valid && !s1_stall;
  assign accept     = bus.cmd_valid && bus.cmd_ready;

  assign bus.cmd_ready = !s1_valid || s1_advance;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.ovf_flag  = ovf_flag;

  assign sum  = s1_opa + s1_opb;
  assign diff = s1_opa - s1_opb;

  always_comb begin
    alu_result = s1_wdata;
    alu_ovf    = 1'b0;
    case (s1_op)
      OP_ADD: begin
        alu_result = sum;
        alu_ovf    = (s1_opa[MSB] == s1_opb[MSB]) && (sum[MSB] != s1_opa[MSB]);
      end
      OP_SUB: begin
        alu_result = diff;
        alu_ovf    = (s1_opa[MSB] != s1_opb[MSB]) && (diff[MSB] != s1_opa[MSB]);
      end
      OP_AND:  alu_result = s1_opa & s1_opb;
      OP_OR:   alu_result = s1_opa | s1_opb;
      default: ;
    endcase
`ifdef PIM_SAT_EN
    // Both overflow cases run away in the direction of operand A's sign.
    if (alu_ovf)
      alu_result = s1_opa[MSB] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
`endif
  end

  // Writing commands never stall, so the S1 result lands in the array at the same edge the new operands are captured.
  assign fwd_a = (s1_writes && (s1_addr_result == bus.addr_a)) ? alu_result : mem[bus.addr_a];
  assign fwd_b = (s1_writes && (s1_addr_result == bus.addr_b)) ? alu_result : mem[bus.addr_b];

  always_ff @(posedge clk) begin
    if (s1_writes)
      mem[s1_addr_result] <= alu_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid       <= 1'b0;
      s1_op          <= OP_NOP;
      s1_addr_result <= '0;
      s1_wdata       <= '0;
      s1_opa         <= '0;
      s1_opb         <= '0;
    end else if (bus.cmd_ready) begin
      s1_valid <= bus.cmd_valid;
      if (accept) begin
        s1_op          <= op_t'(bus.opcode);
        s1_addr_result <= bus.addr_result;
        s1_wdata       <= bus.write_data;
        s1_opa         <= fwd_a;
        s1_opb         <= fwd_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      ovf_flag  <= 1'b0;
    end else begin
      if (s1_advance && (s1_op == OP_READ)) begin
        rsp_valid <= 1'b1;
        rsp_data  <= s1_opa;
      end else if (bus.rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (s1_writes && alu_ovf)
        ovf_flag <= 1'b1;
      else if (bus.flag_clr)
        ovf_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pim_pipe_core.sv
// Self-checking bench for pim_pipe_core: directed scenarios plus randomized traffic
// checked against an in-order architectural model (commands execute atomically on acceptance).
module tb_pim_pipe_core;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  pim_pipe_core_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  pim_pipe_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;

  logic [DATA_W-1:0] ref_mem [2**ADDR_W];
  logic [DATA_W-1:0] exp_q [$];
  bit                model_ovf = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected)
      passes++;
    else
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, actual, expected);
  endtask

  function automatic logic [DATA_W-1:0] ref_alu(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b, output bit ovf);
    longint sa;
    longint sb;
    longint full;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ovf  = 1'b0;
    full = 0;
    case (op)
      3'b000:  full = sa + sb;
      3'b001:  full = sa - sb;
      3'b010:  return a & b;
      default: return a | b;
    endcase
    ovf = (full > 64'sd2147483647) || (full < -64'sd2147483648);
`ifdef PIM_SAT_EN
    if (full > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (full < -64'sd2147483648) return 32'h8000_0000;
`else
`endif
    return full[DATA_W-1:0];
  endfunction

  task automatic model_exec(input logic [2:0] op, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                            input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] wd);
    bit o;
    case (op)
      3'b000, 3'b001, 3'b010, 3'b011: begin
        ref_mem[r] = ref_alu(op, ref_mem[a], ref_mem[b], o);
        if (o) model_ovf = 1'b1;
      end
      3'b100:  ref_mem[r] = wd;
      3'b111:  exp_q.push_back(ref_mem[a]);
      default: ;
    endcase
  endtask

  // Drive one cycle at the negedge, resolve both handshakes just after, then advance one clock.
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [ADDR_W-1:0] a,
                               input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] r,
                               input logic [DATA_W-1:0] wd, output bit acc);
    bus.cmd_valid   = v;
    bus.opcode      = op;
    bus.addr_a      = a;
    bus.addr_b      = b;
    bus.addr_result = r;
    bus.write_data  = wd;
    #1;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0)
        checkOutput("rsp_unexpected", 64'd1, 64'd0);
      else
        checkOutput("rsp_data", bus.rsp_data, exp_q.pop_front());
    end
    acc = bus.cmd_valid && bus.cmd_ready;
    if (acc) model_exec(op, a, b, r, wd);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'b101, '0, '0, '0, '0, acc);
  endtask

  task automatic issue(input logic [2:0] op, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                       input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] wd, output int tries);
    bit acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      applyStimulus(1'b1, op, a, b, r, wd, acc);
      tries++;
    end
    if (!acc) checkOutput("cmd_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [2:0] op, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                      input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] wd);
    int t;
    issue(op, a, b, r, wd, t);
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("rsp_idle", bus.rsp_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t1, t2, t3, acc_total;
    bit acc;
    bit have_cmd;
    logic        rv;
    logic [2:0]  rop;
    logic [ADDR_W-1:0] ra, rb, rr;
    logic [DATA_W-1:0] rwd;
    logic [DATA_W-1:0] held;

    bus.cmd_valid = 0; bus.opcode = 3'b101; bus.addr_a = '0; bus.addr_b = '0;
    bus.addr_result = '0; bus.write_data = '0; bus.rsp_ready = 1'b1; bus.flag_clr = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("rst_rsp_data", bus.rsp_data, '0);
    checkOutput("rst_ovf", bus.ovf_flag, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_cmd_ready", bus.cmd_ready, 1'b1);

    // Basic write/read and one-cycle read latency.
    send(3'b100, '0, '0, 10'h000, 32'd20);
    send(3'b111, 10'h000, '0, '0, '0);
    checkOutput("rd_not_early", bus.rsp_valid, 1'b0);
    idle(1);
    checkOutput("rd_latency", bus.rsp_valid, 1'b1);
    drain();
    send(3'b100, '0, '0, 10'h3FF, 32'd91);
    send(3'b111, 10'h3FF, '0, '0, '0);
    drain();

    // ALU ops into 0x100-0x103, then an unchanged location under opcodes 110/101.
    send(3'b000, 10'h000, 10'h3FF, 10'h100, '0);
    send(3'b001, 10'h000, 10'h3FF, 10'h101, '0);
    send(3'b010, 10'h000, 10'h3FF, 10'h102, '0);
    send(3'b011, 10'h000, 10'h3FF, 10'h103, '0);
    for (int i = 0; i < 4; i++) send(3'b111, 10'h100 + 10'(i), '0, '0, '0);
    drain();
    checkOutput("alu_no_ovf", bus.ovf_flag, model_ovf);
    send(3'b100, '0, '0, 10'h104, 32'h1234);
    send(3'b110, '0, '0, 10'h104, 32'hDEAD);
    send(3'b101, '0, '0, 10'h104, 32'hBEEF);
    send(3'b111, 10'h104, '0, '0, '0);
    drain();

    // Overflow then clear, then underflow.
    send(3'b100, '0, '0, 10'h001, 32'h7FFF_FFFF);
    send(3'b000, 10'h001, 10'h000, 10'h105, '0);
    idle(2);
    checkOutput("ovf_set", bus.ovf_flag, model_ovf);
    send(3'b111, 10'h105, '0, '0, '0);
    drain();
    bus.flag_clr = 1'b1;
    idle(1);
    bus.flag_clr = 1'b0;
    model_ovf = 1'b0;
    checkOutput("ovf_clr", bus.ovf_flag, model_ovf);
    send(3'b100, '0, '0, 10'h002, 32'h8000_0000);
    send(3'b001, 10'h002, 10'h000, 10'h106, '0);
    send(3'b111, 10'h106, '0, '0, '0);
    drain();
    checkOutput("udf_set", bus.ovf_flag, model_ovf);

    // Back-to-back forwarding with both operands on the freshly written address.
    issue(3'b100, '0, '0, 10'h010, 32'd5, t1);
    issue(3'b000, 10'h010, 10'h010, 10'h011, '0, t2);
    issue(3'b111, 10'h011, '0, '0, '0, t3);
    checkOutput("fwd_no_bubble", 64'(t1 + t2 + t3), 64'd3);
    drain();

    // Response backpressure: first read data frozen, second read stalls S1.
    send(3'b100, '0, '0, 10'h020, 32'hA0);
    send(3'b100, '0, '0, 10'h021, 32'hA1);
    send(3'b100, '0, '0, 10'h022, 32'hA2);
    drain();
    bus.rsp_ready = 1'b0;
    send(3'b111, 10'h020, '0, '0, '0);
    send(3'b111, 10'h021, '0, '0, '0);
    checkOutput("bp_cmd_ready_low", bus.cmd_ready, 1'b0);
    held = exp_q[0];
    acc_total = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'b111, 10'h022, '0, '0, '0, acc);
      acc_total += int'(acc);
      checkOutput("bp_rsp_hold_valid", bus.rsp_valid, 1'b1);
      checkOutput("bp_rsp_hold_data", bus.rsp_data, held);
    end
    checkOutput("bp_no_accept", 64'(acc_total), 64'd0);
    bus.rsp_ready = 1'b1;
    send(3'b111, 10'h022, '0, '0, '0);
    drain();

    // Randomized traffic over a small initialized window.
    for (int i = 0; i < 16; i++) send(3'b100, '0, '0, 10'h200 + 10'(i), $urandom);
    have_cmd = 1'b0;
    rv = 0; rop = 0; ra = 0; rb = 0; rr = 0; rwd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!have_cmd) begin
        rv  = ($urandom_range(0, 3) != 0);
        rop = 3'($urandom_range(0, 7));
        ra  = 10'h200 + 10'($urandom_range(0, 15));
        rb  = 10'h200 + 10'($urandom_range(0, 15));
        rr  = 10'h200 + 10'($urandom_range(0, 15));
        rwd = $urandom;
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(rv, rop, ra, rb, rr, rwd, acc);
      have_cmd = rv && !acc;
    end
    drain();
    idle(1);
    checkOutput("rand_ovf", bus.ovf_flag, model_ovf);
    for (int i = 0; i < 16; i++) send(3'b111, 10'h200 + 10'(i), '0, '0, '0);
    drain();

    // Reset mid-stream discards the pending response and the write held in S1.
    send(3'b100, '0, '0, 10'h032, 32'd55);
    send(3'b100, '0, '0, 10'h030, 32'd7);
    send(3'b000, 10'h001, 10'h000, 10'h031, '0);
    idle(2);
    checkOutput("pre_rst_ovf", bus.ovf_flag, 1'b1);
    bus.rsp_ready = 1'b0;
    send(3'b111, 10'h030, '0, '0, '0);
    idle(1);
    checkOutput("pre_rst_rsp_valid", bus.rsp_valid, 1'b1);
    send(3'b100, '0, '0, 10'h032, 32'd99);
    bus.cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("mid_rst_ovf", bus.ovf_flag, 1'b0);
    checkOutput("mid_rst_cmd_ready", bus.cmd_ready, 1'b1);
    exp_q.delete();
    model_ovf = 1'b0;
    ref_mem[10'h032] = 32'd55;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    send(3'b111, 10'h032, '0, '0, '0);
    send(3'b111, 10'h031, '0, '0, '0);
    drain();
    checkOutput("post_rst_ovf", bus.ovf_flag, model_ovf);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pim_pipe_core.md
Name: pim_pipe_core

Overview:
- Parametrised, pipelined successor to the single-cycle PIM module: a DATA_W x 2^ADDR_W in-memory compute array.
- Executes add, sub, and, or, write and read commands on stored operands over a valid/ready command channel.
- Read data returns on a valid/ready response channel.
- Adds a two-stage pipeline, read-after-write forwarding, response backpressure and a sticky overflow flag.

Parameters:
DATA_W, 32, signed word width (two's complement)
ADDR_W, 10, address width; depth = 2^ADDR_W words

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
opcode  in  3  000 add, 001 sub, 010 and, 011 or, 100 write, 101 nop, 110 reserved (nop), 111 read
addr_a  in  ADDR_W  operand A / read address
addr_b  in  ADDR_W  operand B address
addr_result  in  ADDR_W  destination address
write_data  in  DATA_W  data for opcode 100
rsp_valid  out  1  read response valid
rsp_ready  in  1  response consumer ready
rsp_data  out  DATA_W  read response data
ovf_flag  out  1  sticky overflow/underflow flag
flag_clr  in  1  synchronous clear of ovf_flag

Behaviour:
- Reset (rst_n low, asynchronous): cmd_ready=1 after release, rsp_valid=0, rsp_data=0, ovf_flag=0, stage-1 valid=0. Memory contents are not cleared.
- Stage 1 (S1), edge N: on acceptance, S1 captures opcode, addr_result, write_data and operands opa=mem[addr_a], opb=mem[addr_b].
- Stage 2, edge N+1:
  - ALU result written to mem[addr_result] for opcodes 000-100.
  - For read (111), rsp_data<=opa and rsp_valid<=1.
  - 101/110: no memory write, no response.
- Latency: write/ALU result is visible to a command accepted at edge N+1. Read data appears one cycle after acceptance.
- Forwarding: if S1 holds a writing opcode whose addr_result equals the incoming addr_a (or addr_b), the incoming operand takes the S1 result rather than the stale array value. Applies to both operands independently, including addr_a==addr_b.
- Arithmetic: DATA_W-bit wrap-around.
  - add: overflow when sign(a)==sign(b) and sign(sum)!=sign(a).
  - sub: overflow when sign(a)!=sign(b) and sign(diff)!=sign(a).
  - and/or: never overflow.
- ovf_flag: set at the edge where an overflowing result is written. flag_clr clears it; set wins over a simultaneous clear.
- Backpressure:
  - rsp_valid holds with rsp_data stable until rsp_valid && rsp_ready.
  - S1 stalls only if it holds a read while rsp_valid=1 and rsp_ready=0.
  - cmd_ready = !S1_valid || S1_advancing.
  - Back-to-back reads at full throughput when rsp_ready=1.
- Address decode: addresses wrap naturally within 2^ADDR_W. The same address as source and destination is legal (old value used unless forwarded).
- Reset mid-operation: the S1 command and any pending response are discarded, and no memory write occurs for the discarded S1 command.
- cmd_valid with cmd_ready=0: the command is not accepted, and the source holds it stable.

Optional Feature:
- Macro PIM_SAT_EN.
- Defined: add/sub saturate to +2^(DATA_W-1)-1 / -2^(DATA_W-1) on overflow. ovf_flag is still set.
- Undefined: wrap-around results as above.

Test Plan:
- Write 20 to 0x000, then read 0x000 -> rsp_valid one cycle after acceptance, rsp_data=20; repeat with 91 at 0x3FF -> 91.
- mem[0]=20, mem[0x3FF]=91; add, sub, and, or to 0x100-0x103, then read each -> 111, -71, 16, 95; ovf_flag=0. Write to 0x104 with opcode 110, then read -> prior contents unchanged.
- Overflow: mem[1]=0x7FFFFFFF, mem[0]=20, add to 0x105 -> read 0x80000013 (wrap) or 0x7FFFFFFF (PIM_SAT_EN); ovf_flag=1. flag_clr -> 0.
- Underflow: mem[2]=0x80000000, sub mem[2]-mem[0] to 0x106 -> 0x7FFFFFEC (wrap) or 0x80000000 (PIM_SAT_EN); ovf_flag=1.
- Forwarding: write 5 to 0x010, next cycle add 0x010+0x010 to 0x011, next cycle read 0x011 -> 10, no bubbles (cmd_ready stays 1).
- Backpressure and reset: rsp_ready=0 and issue 3 reads -> rsp_data frozen on first, cmd_ready=0 while the second sits in S1. Release rsp_ready -> the 3 responses arrive in order. Assert rst_n low mid-stream -> rsp_valid=0, ovf_flag=0 immediately.
